sram_arbiter: RTL and testbench

- Shares the single external 8-bit async SRAM (upper data byte, 21-bit address) between two requesters.
- Port A is the Oric core RAM path: high priority, latency-sensitive.
- Port B is a low-priority bulk path, e.g. disk-image/tape loader or FDD sector cache.
- Sequences SRAM address, WE and bus direction with a fixed access window and a turnaround cycle; returns read data with a one-cycle ack pulse per port.

---
 rtl/sram_arbiter_if.sv | 45 ++++
 rtl/sram_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the two requester ports, the external SRAM pins and busy.
//   a_*/b_*  : request strobe, we, addr, wdata (to arbiter); rdata, ack (from arbiter)
//   sram_*   : addr, dout, dq_oe, we_n (from arbiter); din (to arbiter)
//   busy     : arbiter not idle
// Modports: slave = arbiter side, master = requesters + SRAM side.
interface sram_arbiter_if #(
   parameter int unsigned ADDR_W = 21
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [7:0]        a_wdata;
   logic [7:0]        a_rdata;
   logic              a_ack;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [7:0]        b_wdata;
   logic [7:0]        b_rdata;
   logic              b_ack;

   logic [ADDR_W-1:0] sram_addr;
   logic [7:0]        sram_dout;
   logic [7:0]        sram_din;
   logic              sram_dq_oe;
   logic              sram_we_n;
   logic              busy;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  sram_din,
      output a_rdata, a_ack, b_rdata, b_ack,
      output sram_addr, sram_dout, sram_dq_oe, sram_we_n, busy
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output sram_din,
      input  a_rdata, a_ack, b_rdata, b_ack,
      input  sram_addr, sram_dout, sram_dq_oe, sram_we_n, busy
   );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external 8-bit async SRAM between a high-priority port A
// (core RAM path) and a low-priority bulk port B. Each access is a fixed window of
// ACCESS_CYCLES clocks followed by one turnaround cycle carrying the ack pulse.
// Ports:
//   clk_sys, reset (synchronous, active-high)
//   bus (sram_arbiter_if.slave): a_*/b_* requester ports, sram_* pins, busy
// Build option: define ARB_FAIR_EN to let B win after B_MAX_SKIP A grants it lost.
module sram_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned ADDR_W        = 21,
   parameter int unsigned B_MAX_SKIP    = 3
) (
   input  logic           clk_sys,
   input  logic           reset,
   sram_arbiter_if.slave  bus
);
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 8;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

   if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15 || B_MAX_SKIP == 0) begin : g_param_check
      $error("sram_arbiter: illegal ACCESS_CYCLES or B_MAX_SKIP");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_TURN} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              port_b_q, port_b_d;
   logic              we_q, we_d;
   req_t              hold_a_q, hold_a_d, hold_b_q, hold_b_d;
   logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0] sram_dout_q, sram_dout_d;
   logic              sram_dq_oe_q, sram_dq_oe_d;
   logic              sram_we_n_q, sram_we_n_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic              busy_q, busy_d;

   req_t live_a, live_b, sel_a, sel_b, sel;
   logic cand_a, cand_b, grant_a, grant_b, svc_a, svc_b;

`ifdef ARB_FAIR_EN
   localparam int unsigned SKIP_W = $clog2(B_MAX_SKIP + 1);
   logic [SKIP_W-1:0] skip_b_q, skip_b_d;
`endif

   // Arbitration: a live strobe in IDLE competes directly; otherwise the held copy is used.
   always_comb begin
      live_a  = '{we: bus.a_we, addr: bus.a_addr, wdata: bus.a_wdata};
      live_b  = '{we: bus.b_we, addr: bus.b_addr, wdata: bus.b_wdata};
      sel_a   = pend_a_q ? hold_a_q : live_a;
      sel_b   = pend_b_q ? hold_b_q : live_b;
      cand_a  = bus.a_req | pend_a_q;
      cand_b  = bus.b_req | pend_b_q;
`ifdef ARB_FAIR_EN
      grant_b = (state_q == ST_IDLE) && cand_b &&
                (!cand_a || skip_b_q == SKIP_W'(B_MAX_SKIP));
`else
      grant_b = (state_q == ST_IDLE) && cand_b && !cand_a;
`endif
      grant_a = (state_q == ST_IDLE) && cand_a && !grant_b;
      sel     = grant_b ? sel_b : sel_a;
      svc_a   = (state_q == ST_ACCESS) && !port_b_q;
      svc_b   = (state_q == ST_ACCESS) &&  port_b_q;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      port_b_d     = port_b_q;
      we_d         = we_q;
      hold_a_d     = hold_a_q;
      hold_b_d     = hold_b_q;
      pend_a_d     = pend_a_q;
      pend_b_d     = pend_b_q;
      sram_addr_d  = sram_addr_q;
      sram_dout_d  = sram_dout_q;
      sram_dq_oe_d = sram_dq_oe_q;
      sram_we_n_d  = sram_we_n_q;
      a_rdata_d    = a_rdata_q;
      b_rdata_d    = b_rdata_q;
      a_ack_d      = 1'b0;
      b_ack_d      = 1'b0;
`ifdef ARB_FAIR_EN
      skip_b_d     = skip_b_q;
`endif

      // A strobe is latched only if nothing is already held or in service for that port.
      if (bus.a_req && !pend_a_q && !svc_a) begin
         pend_a_d = 1'b1;
         hold_a_d = live_a;
      end
      if (bus.b_req && !pend_b_q && !svc_b) begin
         pend_b_d = 1'b1;
         hold_b_d = live_b;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (grant_a || grant_b) begin
               state_d      = ST_ACCESS;
               cnt_d        = '0;
               port_b_d     = grant_b;
               we_d         = sel.we;
               sram_addr_d  = sel.addr;
               sram_dout_d  = sel.wdata;
               sram_dq_oe_d = sel.we;
               sram_we_n_d  = ~sel.we;
               if (grant_b) pend_b_d = 1'b0;
               else         pend_a_d = 1'b0;
`ifdef ARB_FAIR_EN
               if (grant_b)
                  skip_b_d = '0;
               else if (cand_b && skip_b_q != SKIP_W'(B_MAX_SKIP))
                  skip_b_d = skip_b_q + SKIP_W'(1);
`endif
            end
         end
         ST_ACCESS: begin
            if (cnt_q == LAST_CNT) begin
               state_d      = ST_TURN;
               sram_dq_oe_d = 1'b0;
               sram_we_n_d  = 1'b1;
               if (port_b_q) begin
                  b_ack_d = 1'b1;
                  if (!we_q) b_rdata_d = bus.sram_din;
               end else begin
                  a_ack_d = 1'b1;
                  if (!we_q) a_rdata_d = bus.sram_din;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               // WE rises one cycle early so address/data hold past the write edge.
               if (cnt_d == LAST_CNT) sram_we_n_d = 1'b1;
            end
         end
         ST_TURN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         port_b_q     <= 1'b0;
         we_q         <= 1'b0;
         hold_a_q     <= '0;
         hold_b_q     <= '0;
         pend_a_q     <= 1'b0;
         pend_b_q     <= 1'b0;
         sram_addr_q  <= '0;
         sram_dout_q  <= '0;
         sram_dq_oe_q <= 1'b0;
         sram_we_n_q  <= 1'b1;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
         a_ack_q      <= 1'b0;
         b_ack_q      <= 1'b0;
         busy_q       <= 1'b0;
`ifdef ARB_FAIR_EN
         skip_b_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         port_b_q     <= port_b_d;
         we_q         <= we_d;
         hold_a_q     <= hold_a_d;
         hold_b_q     <= hold_b_d;
         pend_a_q     <= pend_a_d;
         pend_b_q     <= pend_b_d;
         sram_addr_q  <= sram_addr_d;
         sram_dout_q  <= sram_dout_d;
         sram_dq_oe_q <= sram_dq_oe_d;
         sram_we_n_q  <= sram_we_n_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
         a_ack_q      <= a_ack_d;
         b_ack_q      <= b_ack_d;
         busy_q       <= busy_d;
`ifdef ARB_FAIR_EN
         skip_b_q     <= skip_b_d;
`endif
      end
   end

   assign bus.sram_addr  = sram_addr_q;
   assign bus.sram_dout  = sram_dout_q;
   assign bus.sram_dq_oe = sram_dq_oe_q;
   assign bus.sram_we_n  = sram_we_n_q;
   assign bus.a_rdata    = a_rdata_q;
   assign bus.b_rdata    = b_rdata_q;
   assign bus.a_ack      = a_ack_q;
   assign bus.b_ack      = b_ack_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;
   localparam int unsigned ACC     = 2;
   localparam int unsigned AW      = 21;
   localparam int unsigned MAXSKIP = 3;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_sys = ~clk_sys;

   sram_arbiter_if #(.ADDR_W(AW)) bus ();

   sram_arbiter #(.ACCESS_CYCLES(ACC), .ADDR_W(AW), .B_MAX_SKIP(MAXSKIP)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   typedef struct {
      logic       we;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_a[$];
   exp_t       exp_b[$];
   logic [7:0] ref_mem  [logic [AW-1:0]];
   logic [7:0] sram_mem [logic [AW-1:0]];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int a_ack_cnt = 0, b_ack_cnt = 0, last_a_ack = -1, last_b_ack = -1;
   logic prev_a_ack = 1'b0, prev_b_ack = 1'b0, prev_we_n = 1'b1;

   always @(posedge clk_sys) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic logic [7:0] sram_rd(input logic [AW-1:0] a);
      return sram_mem.exists(a) ? sram_mem[a] : 8'h00;
   endfunction

   // Async SRAM model: a write commits when WE rises while data is still being driven.
   always @(negedge clk_sys) begin
      if (!prev_we_n && bus.sram_we_n && bus.sram_dq_oe) sram_mem[bus.sram_addr] = bus.sram_dout;
      if (!bus.sram_we_n) chk("we_low_needs_oe", 32'(bus.sram_dq_oe), 32'd1);
      prev_we_n    = bus.sram_we_n;
      bus.sram_din = sram_rd(bus.sram_addr);
   end

   // Scoreboard monitor: every ack pops the oldest expectation for that port.
   always @(negedge clk_sys) begin
      exp_t e;
      if (reset) begin
         prev_a_ack = 1'b0;
         prev_b_ack = 1'b0;
      end else begin
         if (bus.a_ack) begin
            a_ack_cnt++;
            last_a_ack = cyc;
            chk("a_ack_single_cycle", 32'(prev_a_ack), 32'd0);
            chk("a_ack_expected", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) begin
               e = exp_a.pop_front();
               if (!e.we) chk("a_rdata", 32'(bus.a_rdata), 32'(e.data));
            end
         end
         if (bus.b_ack) begin
            b_ack_cnt++;
            last_b_ack = cyc;
            chk("b_ack_single_cycle", 32'(prev_b_ack), 32'd0);
            chk("b_ack_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
               e = exp_b.pop_front();
               if (!e.we) chk("b_rdata", 32'(bus.b_rdata), 32'(e.data));
            end
         end
         prev_a_ack = bus.a_ack;
         prev_b_ack = bus.b_ack;
      end
   end

   // Drive a strobe; when tracked, the reference memory and expectation queue are updated.
   task automatic issue(input bit pb, input bit we, input logic [AW-1:0] addr,
                        input logic [7:0] d, input bit track);
      exp_t e;
      if (track) begin
         if (we) ref_mem[addr] = d;
         e.we   = we;
         e.data = ref_rd(addr);
         if (pb) exp_b.push_back(e);
         else    exp_a.push_back(e);
      end
      if (pb) begin
         bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d;
      end else begin
         bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d;
      end
   endtask

   task automatic drop();
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      sram_mem[a] = d;
      ref_mem[a]  = d;
   endtask

   task automatic wait_idle(input int max_cyc);
      int w = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0 || bus.busy) && w < max_cyc) begin
         @(negedge clk_sys);
         w++;
      end
      chk("drain", 32'(exp_a.size() + exp_b.size()), 32'd0);
      @(posedge clk_sys); #1;
   endtask

   function automatic logic [AW-1:0] rnd_a_addr();
      return AW'($urandom_range(0, 63));
   endfunction

   function automatic logic [AW-1:0] rnd_b_addr();
      return AW'(32'h100000 + $urandom_range(0, 63));
   endfunction

   initial begin
      int t, oe_cnt, wen_cnt, ack_at, base_a, base_b, n_a_before_b, issued, exp_nb;
      bit got;
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
      bus.sram_din = '0;

      // Reset values
      repeat (3) @(posedge clk_sys);
      #1 reset = 1'b0;
      @(negedge clk_sys);
      chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("rst_addr", 32'(bus.sram_addr), 32'd0);
      chk("rst_dout", 32'(bus.sram_dout), 32'd0);
      chk("rst_a_ack", 32'(bus.a_ack), 32'd0);
      chk("rst_b_ack", 32'(bus.b_ack), 32'd0);
      chk("rst_a_rdata", 32'(bus.a_rdata), 32'd0);
      chk("rst_b_rdata", 32'(bus.b_rdata), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk_sys); #1;

      // A read timing
      preload(21'h01234, 8'h5A);
      t = cyc;
      issue(1'b0, 1'b0, 21'h01234, 8'h00, 1'b1);
      @(posedge clk_sys); #1; drop();
      for (int k = 1; k <= int'(ACC) + 2; k++) begin
         @(negedge clk_sys);
         if (k <= int'(ACC)) chk("a_rd_addr", 32'(bus.sram_addr), 32'h01234);
         chk("a_rd_we_n", 32'(bus.sram_we_n), 32'd1);
         chk("a_rd_ack_timing", 32'(bus.a_ack), 32'(k == int'(ACC) + 1));
      end
      wait_idle(40);
      chk("a_rd_data_hold", 32'(bus.a_rdata), 32'h5A);

      // B write of the top address, then read back
      issue(1'b1, 1'b1, 21'h1FFFFF, 8'hC3, 1'b1);
      @(posedge clk_sys); #1; drop();
      oe_cnt = 0; wen_cnt = 0; ack_at = -1;
      for (int k = 1; k <= int'(ACC) + 3; k++) begin
         @(negedge clk_sys);
         if (bus.sram_dq_oe) oe_cnt++;
         if (!bus.sram_we_n) wen_cnt++;
         if (bus.b_ack) ack_at = k;
      end
      chk("b_wr_oe_cycles", 32'(oe_cnt), 32'(ACC));
      chk("b_wr_we_cycles", 32'(wen_cnt), 32'(ACC - 1));
      chk("b_wr_ack_latency", 32'(ack_at), 32'(ACC + 1));
      wait_idle(40);
      issue(1'b1, 1'b0, 21'h1FFFFF, 8'h00, 1'b1);
      @(posedge clk_sys); #1; drop();
      wait_idle(40);
      chk("b_readback", 32'(bus.b_rdata), 32'hC3);

      // Simultaneous strobes: A first, B immediately after
      preload(21'h00100, 8'hA1);
      preload(21'h100100, 8'hB2);
      t = cyc;
      issue(1'b0, 1'b0, 21'h00100, 8'h00, 1'b1);
      issue(1'b1, 1'b0, 21'h100100, 8'h00, 1'b1);
      @(posedge clk_sys); #1; drop();
      wait_idle(60);
      chk("sim_a_ack_cycle", 32'(last_a_ack - t), 32'(ACC + 1));
      chk("sim_b_ack_cycle", 32'(last_b_ack - t), 32'(2 * ACC + 3));

      // B pending while A re-strobes on every ack
      base_b = b_ack_cnt;
      n_a_before_b = 0;
      issue(1'b0, 1'($urandom_range(0, 1)), rnd_a_addr(), 8'($urandom), 1'b1);
      issue(1'b1, 1'b0, 21'h100020, 8'h00, 1'b1);
      @(posedge clk_sys); #1; drop();
      for (int i = 0; i < 20; i++) begin
         got = 1'b0;
         for (int w = 0; w < 40 && !got; w++) begin
            @(negedge clk_sys);
            if (bus.a_ack) got = 1'b1;
         end
         chk("starve_a_ack_seen", 32'(got), 32'd1);
         if (b_ack_cnt == base_b) n_a_before_b = i + 1;
         if (got && i < 19) begin
            issue(1'b0, 1'($urandom_range(0, 1)), rnd_a_addr(), 8'($urandom), 1'b1);
            @(posedge clk_sys); #1; drop();
         end
      end
      wait_idle(100);
`ifdef ARB_FAIR_EN
      exp_nb = int'(MAXSKIP);
`else
      exp_nb = 20;
`endif
      chk("a_grants_before_b", 32'(n_a_before_b), 32'(exp_nb));
      chk("b_served_once", 32'(b_ack_cnt - base_b), 32'd1);

      // Second A strobe while the first is still pending is ignored
      preload(21'h00111, 8'h3C);
      preload(21'h00222, 8'h96);
      base_a = a_ack_cnt;
      issue(1'b1, 1'b0, 21'h100005, 8'h00, 1'b1);
      @(posedge clk_sys); #1; drop();
      issue(1'b0, 1'b0, 21'h00111, 8'h00, 1'b1);
      @(posedge clk_sys); #1; drop();
      issue(1'b0, 1'b0, 21'h00222, 8'h00, 1'b0);
      @(posedge clk_sys); #1; drop();
      wait_idle(60);
      chk("a_second_strobe_ignored", 32'(a_ack_cnt - base_a), 32'd1);
      chk("a_hold_keeps_first_addr", 32'(bus.a_rdata), 32'h3C);

      // Reset in the first cycle of a write, with B pending
      preload(21'h0ABCD, 8'h77);
      preload(21'h1ABCD, 8'h55);
      base_a = a_ack_cnt;
      base_b = b_ack_cnt;
      issue(1'b0, 1'b1, 21'h0ABCD, 8'hEE, 1'b0);
      issue(1'b1, 1'b1, 21'h1ABCD, 8'h44, 1'b0);
      @(posedge clk_sys); #1; drop();
      reset = 1'b1;
      @(posedge clk_sys); #1;
      reset = 1'b0;
      @(negedge clk_sys);
      chk("rst_mid_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rst_mid_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      chk("rst_mid_a_rdata", 32'(bus.a_rdata), 32'd0);
      chk("rst_mid_b_rdata", 32'(bus.b_rdata), 32'd0);
      repeat (12) @(negedge clk_sys);
      chk("rst_mid_no_a_ack", 32'(a_ack_cnt - base_a), 32'd0);
      chk("rst_mid_no_b_ack", 32'(b_ack_cnt - base_b), 32'd0);
      chk("rst_mid_busy_after", 32'(bus.busy), 32'd0);
      chk("rst_mid_sram_a_kept", 32'(sram_rd(21'h0ABCD)), 32'(ref_rd(21'h0ABCD)));
      chk("rst_mid_sram_b_kept", 32'(sram_rd(21'h1ABCD)), 32'(ref_rd(21'h1ABCD)));
      @(posedge clk_sys); #1;

      // Randomized traffic on both ports
      issued = 0;
      for (int c = 0; c < 4000 && (issued < 120 || exp_a.size() != 0 || exp_b.size() != 0); c++) begin
         @(posedge clk_sys); #1; drop();
         if (issued < 120 && exp_a.size() == 0 && $urandom_range(0, 2) == 0) begin
            issue(1'b0, 1'($urandom_range(0, 1)), rnd_a_addr(), 8'($urandom), 1'b1);
            issued++;
         end
         if (issued < 120 && exp_b.size() == 0 && $urandom_range(0, 2) == 0) begin
            issue(1'b1, 1'($urandom_range(0, 1)), rnd_b_addr(), 8'($urandom), 1'b1);
            issued++;
         end
      end
      drop();
      wait_idle(200);
      for (int i = 0; i < 64; i++) begin
         chk("final_mem_a", 32'(sram_rd(AW'(i))), 32'(ref_rd(AW'(i))));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
